// File: rtl/afifo_wr_ctrl.sv
// afifo_wr_ctrl: write-side pointer controller for a dual-clock FIFO.
// Everything here runs on the write clock. The block keeps the binary
// write pointer, exports a registered gray copy to the read domain,
// resynchronizes the read domain's gray pointer through two flops and
// derives full / almost_full / fill level / overflow from it.
// Pointers are PTR+1 bits wide; the extra top bit distinguishes a full
// FIFO from an empty one. The full comparison needs PTR >= 2.
module afifo_wr_ctrl #(
    parameter int PTR       = 8,
    parameter int AF_MARGIN = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [PTR:0]   rptr_gray_in,
    output logic [PTR-1:0] waddr,
    output logic           ram_we,
    output logic [PTR:0]   wptr_gray,
    output logic           full,
    output logic           almost_full,
    output logic [PTR:0]   wr_level,
    output logic           overflow
);

    // almost_full trips once the occupancy leaves AF_MARGIN or fewer free slots
    localparam int           AF_THRESH_I = (1 << PTR) - AF_MARGIN;
    localparam logic [PTR:0] AF_THRESH   = AF_THRESH_I[PTR:0];
    localparam logic [PTR:0] PTR_ONE     = {{PTR{1'b0}}, 1'b1};

    logic [PTR:0] wbin;
    logic [PTR:0] wbin_next;
    logic [PTR:0] wgray_next;
    logic [PTR:0] rq1;
    logic [PTR:0] rq2;
    logic [PTR:0] rbin;
    logic [PTR:0] level_next;
    logic [PTR:0] full_pattern;
    logic         accept;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it
    function automatic logic [PTR:0] gray_to_bin(input logic [PTR:0] g);
        logic [PTR:0] b;
        b = '0;
        for (int i = 0; i <= PTR; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Two-flop synchronizer for the read pointer coming from the other clock
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rptr_gray_in;
            rq2 <= rq1;
        end
    end

    // Next-pointer, gray, level and full-pattern arithmetic for this cycle
    always_comb begin
        accept       = wr_en & ~full;
        wbin_next    = accept ? (wbin + PTR_ONE) : wbin;
        wgray_next   = wbin_next ^ (wbin_next >> 1);
        rbin         = gray_to_bin(rq2);
        level_next   = wbin_next - rbin;
        full_pattern = {~rq2[PTR], ~rq2[PTR-1], rq2[PTR-2:0]};
    end

    // RAM write port: strobe is suppressed while the block is held in reset
    always_comb begin
        ram_we = accept & rst_n;
        waddr  = wbin[PTR-1:0];
    end

    // Pointer and flag registers; flags use the synchronized (stale) read pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= (wgray_next == full_pattern);
            almost_full <= (level_next >= AF_THRESH);
            wr_level    <= level_next;
            overflow    <= overflow | (wr_en & full);
        end
    end

endmodule
